mem_master: RTL and testbench

Sequential initiator for the processor's single-port data RAM. Accepts single-word or burst read/write commands from the datapath (and from game-logic engines such as screen clear and score-table dump), drives the RAM's `en`/`memwrite`/`memread`/`adr`/`writedata` port, and absorbs the RAM's one-cycle registered read latency. Read data returns as a cycle-contiguous stream with a last-word marker; write bursts fill consecutive addresses with one constant word (memset).

---
 rtl/mem_master_pkg.sv | 23 ++
 rtl/rd_latency_pipe.sv | 37 +++
 rtl/mem_master.sv | 133 +++++++++++++
 tb/tb_mem_master.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mem_master_pkg.sv
// Shared types for the data-RAM initiator: FSM encoding, default widths
// and the command record used by callers.
package mem_master_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int LEN_W_DEF  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [WIDTH_DEF-1:0]  wdata;
    logic [LEN_W_DEF-1:0]  len;
  } cmd_t;

endpackage

// File: rtl/rd_latency_pipe.sv
// Valid/last shift register matching the RAM read latency plus the
// response data register. DEPTH must be at least 2.
module rd_latency_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_last,
  output logic pre_last,
  output logic out_vld,
  output logic out_last
);

  logic [DEPTH:1] vld_pipe;
  logic [DEPTH:1] lst_pipe;

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pipe <= '0;
      lst_pipe <= '0;
    end else begin
      vld_pipe[1] <= push;
      lst_pipe[1] <= push & push_last;
      for (int i = 2; i <= DEPTH; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        lst_pipe[i] <= lst_pipe[i-1];
      end
    end
  end

  // One stage before the output: lets the FSM register done in step with rsp_last.
  assign pre_last = lst_pipe[DEPTH-1];
  assign out_vld  = vld_pipe[DEPTH];
  assign out_last = lst_pipe[DEPTH];

endmodule

// File: rtl/mem_master.sv
// Burst read / fill-write initiator for the single-port data RAM with
// one-cycle registered read latency. All outputs are registered.
module mem_master
  import mem_master_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              rsp_last,
  output logic              done,
  output logic              mem_en,
  output logic              mem_memwrite,
  output logic              mem_memread,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [WIDTH-1:0]  mem_writedata,
  input  logic [WIDTH-1:0]  mem_memdata
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] nxt_adr, nxt_adr_n;
  logic [LEN_W-1:0]  cnt, cnt_n;
  logic              we_n, re_n, done_n;
  logic [ADDR_W-1:0] adr_n;
  logic [WIDTH-1:0]  wd_n;
  logic              pre_last;

  // cnt = words still to issue after the one currently on the RAM port.
  always_comb begin
    state_n   = state;
    nxt_adr_n = nxt_adr;
    cnt_n     = cnt;
    we_n      = 1'b0;
    re_n      = 1'b0;
    done_n    = 1'b0;
    adr_n     = mem_adr;
    wd_n      = mem_writedata;
    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          adr_n     = req_addr;
          nxt_adr_n = req_addr + 1'b1;
          cnt_n     = req_len;
          wd_n      = req_wdata;
          if (req_write) begin
            we_n    = 1'b1;
            state_n = S_WRITE;
          end else begin
            re_n    = 1'b1;
            state_n = S_READ;
          end
        end
      end
      S_WRITE: begin
        if (cnt == '0) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else begin
          we_n      = 1'b1;
          adr_n     = nxt_adr;
          nxt_adr_n = nxt_adr + 1'b1;
          cnt_n     = cnt - 1'b1;
        end
      end
      S_READ: begin
        if (cnt == '0) begin
          state_n = S_DRAIN;
        end else begin
          re_n      = 1'b1;
          adr_n     = nxt_adr;
          nxt_adr_n = nxt_adr + 1'b1;
          cnt_n     = cnt - 1'b1;
        end
      end
      S_DRAIN: begin
        if (pre_last) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IDLE;
      nxt_adr       <= '0;
      cnt           <= '0;
      req_ready     <= 1'b0;
      done          <= 1'b0;
      mem_en        <= 1'b0;
      mem_memwrite  <= 1'b0;
      mem_memread   <= 1'b0;
      mem_adr       <= '0;
      mem_writedata <= '0;
      rsp_data      <= '0;
    end else begin
      state         <= state_n;
      nxt_adr       <= nxt_adr_n;
      cnt           <= cnt_n;
      req_ready     <= (state_n == S_IDLE);
      done          <= done_n;
      mem_en        <= we_n | re_n;
      mem_memwrite  <= we_n;
      mem_memread   <= re_n;
      mem_adr       <= adr_n;
      mem_writedata <= wd_n;
      rsp_data      <= mem_memdata;
    end
  end

  rd_latency_pipe #(.DEPTH(2)) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .push      (mem_memread),
    .push_last (state == S_READ && cnt == '0),
    .pre_last  (pre_last),
    .out_vld   (rsp_valid),
    .out_last  (rsp_last)
  );

endmodule

// File: tb/tb_mem_master.sv
// Randomized self-checking bench for mem_master: behavioural RAM, shadow
// memory reference and per-cycle expected protocol timing.
module tb_mem_master;
  import mem_master_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr, req_wdata;
  logic [7:0]  req_len;
  logic        rsp_valid, rsp_last, done;
  logic [15:0] rsp_data;
  logic        mem_en, mem_memwrite, mem_memread;
  logic [15:0] mem_adr, mem_writedata, mem_memdata;

  logic [15:0] ram [0:65535];
  logic [15:0] ref_mem [0:65535];
  int nchk = 0;
  int npass = 0;

  always #5 clk = ~clk;

  mem_master dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .done(done), .mem_en(mem_en), .mem_memwrite(mem_memwrite),
    .mem_memread(mem_memread), .mem_adr(mem_adr),
    .mem_writedata(mem_writedata), .mem_memdata(mem_memdata)
  );

  // Single-port RAM with registered read
  always @(posedge clk) begin
    if (mem_en && mem_memwrite) ram[mem_adr] <= mem_writedata;
    if (mem_en && mem_memread)  mem_memdata  <= ram[mem_adr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Offer a command, wait for acceptance, then check every cycle of the
  // transaction against the expected timeline.
  task automatic run_cmd(input cmd_t c);
    int n, last, tmo;
    logic [15:0] a;
    n = int'(c.len) + 1;
    @(negedge clk);
    req_valid = 1'b1; req_write = c.write; req_addr = c.addr;
    req_wdata = c.wdata; req_len = c.len;
    tmo = 0;
    while (!req_ready && tmo < 50) begin @(negedge clk); tmo++; end
    if (!req_ready) begin chk("accept_timeout", 0, 1); req_valid = 1'b0; return; end
    last = c.write ? n : n + 1;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      if (k == 0) begin
        // Scramble request fields: they must be ignored after the accept edge
        req_valid = 1'b0; req_addr = 16'($urandom); req_wdata = 16'($urandom);
        req_len = 8'($urandom); req_write = 1'($urandom);
      end
      chk("ready", req_ready, k == last);
      chk("done", done, k == last);
      chk("mem_en", mem_en, k < n);
      chk("memwrite", mem_memwrite, c.write && k < n);
      chk("memread", mem_memread, !c.write && k < n);
      if (k < n) begin
        a = c.addr + 16'(k);
        chk("mem_adr", mem_adr, a);
        if (c.write) chk("wdata", mem_writedata, c.wdata);
      end
      if (c.write) chk("rsp_valid_wr", rsp_valid, 0);
      else begin
        chk("rsp_valid", rsp_valid, k >= 2);
        chk("rsp_last", rsp_last, k == last);
        if (k >= 2) begin
          a = c.addr + 16'(k - 2);
          chk("rsp_data", rsp_data, ref_mem[a]);
        end
      end
    end
    if (c.write)
      for (int i = 0; i < n; i++) ref_mem[16'(c.addr + 16'(i))] = c.wdata;
  endtask

  function automatic cmd_t mk(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [7:0] l);
    cmd_t c;
    c.write = w; c.addr = a; c.wdata = d; c.len = l;
    return c;
  endfunction

  initial begin
    cmd_t c;
    int tmo, acc;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 16'(i) ^ 16'hA5A5;
      ref_mem[i] = 16'(i) ^ 16'hA5A5;
    end
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_len = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_en", mem_en, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_done", done, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);

    // Directed cases
    run_cmd(mk(1'b1, 16'h0010, 16'hBEEF, 8'd0));
    chk("ram_0010", ram[16'h0010], 16'hBEEF);
    run_cmd(mk(1'b1, 16'h0100, 16'h0000, 8'd7));
    for (int i = 0; i < 4; i++) ref_mem[16'h20 + i] = 16'(i + 1);
    for (int i = 0; i < 4; i++) ram[16'h20 + i] = 16'(i + 1);
    run_cmd(mk(1'b0, 16'h0020, 16'h0, 8'd3));
    run_cmd(mk(1'b0, 16'hFFFF, 16'h0, 8'd1));

    // Reset during the third issue cycle of a len-7 read
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0300; req_len = 8'd7;
    @(negedge clk);              // cycle T
    req_valid = 1'b0;
    @(negedge clk);              // cycle T+1
    @(negedge clk);              // cycle T+2: third issue
    chk("mid_issue", mem_memread, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_en", mem_en, 0);
    chk("rst_mid_rd", mem_memread, 0);
    chk("rst_mid_wr", mem_memwrite, 0);
    chk("rst_mid_rsp", rsp_valid, 0);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("post_rst_rsp", rsp_valid, 0);
      chk("post_rst_done", done, 0);
      chk("post_rst_ready", req_ready, 1);
    end

    // Back-to-back: read len 0 then a write held on req_valid
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0040; req_len = 8'd0;
    @(negedge clk);              // cycle T
    req_write = 1'b1; req_addr = 16'h0041; req_wdata = 16'h1234;
    tmo = 0; acc = -1;
    while (tmo < 20 && acc < 0) begin
      if (req_ready) acc = tmo;
      else begin @(negedge clk); tmo++; end
    end
    chk("b2b_accept_cycle", acc, 2);
    chk("b2b_done", done, 1);
    chk("b2b_data", rsp_data, ref_mem[16'h0040]);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_wr", mem_memwrite, 1);
    chk("b2b_adr", mem_adr, 16'h0041);
    ref_mem[16'h0041] = 16'h1234;
    repeat (2) @(negedge clk);

    // Random commands over a window straddling the wrap point
    for (int t = 0; t < 40; t++) begin
      c.write = 1'($urandom);
      c.addr  = 16'hFFF0 + 16'($urandom_range(0, 31));
      c.wdata = 16'($urandom);
      c.len   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 5));
      run_cmd(c);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
